// File: rtl/fum_mips_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// parameter defaults and the request error check.
package fum_mips_pkg;

    localparam int unsigned DMEM_DEPTH_DEF = 256;
    localparam int unsigned DMEM_WAIT_DEF  = 2;

    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t ST_IDLE = 2'd0;
    localparam dmem_state_t ST_WAIT = 2'd1;
    localparam dmem_state_t ST_RESP = 2'd2;

    // Misaligned word access or word index beyond the storage depth.
    function automatic logic dmem_addr_err(input logic [31:0] addr,
                                           input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous byte-lane write and a
// registered read port sampled on the same clock edge. Contents are not reset.
module dmem_array
    import fum_mips_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, fixed wait states, response out.
// Optional feature macro: DMEM_BYTE_ENABLE_EN (store honours req_be lanes).
module dmem_responder
    import fum_mips_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
    parameter int unsigned WAIT  = DMEM_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    dmem_state_t   state_q;
    logic [3:0]    cnt_q;
    logic          started_q;
    logic          resp_valid_q;
    logic          write_q;
    logic          err_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;

    logic          accept;
    logic          req_err;
    logic          enter_resp;
    logic          cur_write;
    logic          cur_err;
    logic [AW-1:0] cur_idx;
    logic [31:0]   cur_wdata;
    logic [3:0]    wr_be;
    logic          arr_we;
    logic          arr_re;
    logic [31:0]   arr_rdata;

    assign req_ready = started_q && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_err   = dmem_addr_err(req_addr, DEPTH);

    always_comb begin
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: enter_resp = accept && (WAIT == 0);
            ST_WAIT: enter_resp = (cnt_q == 4'd0);
            default: enter_resp = 1'b0;
        endcase
    end

    // With no wait states the array is accessed on the acceptance edge itself,
    // before the capture registers hold the request, so bypass them in IDLE.
    assign cur_write = (state_q == ST_IDLE) ? req_write : write_q;
    assign cur_err   = (state_q == ST_IDLE) ? req_err : err_q;
    assign cur_idx   = (state_q == ST_IDLE) ? req_addr[AW+1:2] : idx_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

`ifdef DMEM_BYTE_ENABLE_EN
    logic [3:0] be_q;
    assign wr_be = (state_q == ST_IDLE) ? req_be : be_q;
`else
    logic be_unused;
    assign be_unused = ^req_be;
    assign wr_be     = 4'hF;
`endif

    assign arr_we = enter_resp && cur_write && !cur_err;
    assign arr_re = enter_resp && !cur_write && !cur_err;

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (cur_idx),
        .be    (wr_be),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    // resp_valid rises one edge after RESP is entered, so a response always
    // appears WAIT+1 edges after acceptance and a handshake needs that edge too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            started_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
`ifdef DMEM_BYTE_ENABLE_EN
            be_q         <= '0;
`endif
        end else begin
            started_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        write_q <= req_write;
                        err_q   <= req_err;
                        idx_q   <= req_addr[AW+1:2];
                        wdata_q <= req_wdata;
`ifdef DMEM_BYTE_ENABLE_EN
                        be_q    <= req_be;
`endif
                        if (WAIT == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_valid_q && err_q;
    assign resp_rdata = (resp_valid_q && !write_q && !err_q) ? arr_rdata : '0;

endmodule
